mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle MIPS control unit and the successor to the single-cycle decoder. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback, holding in memory states until the memory handshake completes. It drives the multi-cycle datapath's muxes, register and memory enables, and PC enable. It also counts retired instructions and flags unsupported encodings.

## Interface
- `WAIT_MEM`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `opcode` input 6: IR[31:26], sampled in DECODE.
- `funct` input 6: IR[5:0], sampled in DECODE.
- `zero` input 1: ALU zero flag, used in BRANCH.
- `mem_ready` input 1: memory access completes this cycle.
- `pc_en` output 1: PC register load enable.
- `IorD` output 1: memory address source; 0 = PC, 1 = ALUOut.
- `IRWrite` output 1: instruction register load.
- `MemRead` output 1: memory read strobe.
- `MemWrite` output 1: memory write strobe.
- `RegWrite` output 1: register file write.
- `RegDst` output 2: write-register select; 00 = rt, 01 = rd, 10 = $31.
- `MemtoReg` output 2: writeback data select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `ALUSrcA` output 1: ALU A select; 0 = PC, 1 = A.
- `ALUSrcB` output 2: ALU B select; 00 = B, 01 = 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
- `ExtOp` output 1: immediate extension; 1 = sign-extend, 0 = zero-extend.
- `ALUOp` output 3: ALU operation; 000 add, 001 sub, 010 funct-decode, 011 and, 100 or, 101 xor, 110 lui, 111 slt.
- `PCSource` output 2: next-PC select; 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register A.
- `illegal` output 1: one-cycle pulse on an unsupported encoding.
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `instr_count` output CNT_W: number of retired instructions.
- `state` output 4: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, ILL=12.
- All outputs are decoded from the registered state and the DECODE-latched opcode/funct. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite and pc_en assert only in the cycle with `mem_ready`=1; that cycle also moves to DECODE. Otherwise the FSM holds in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut).
  - Latch opcode/funct and dispatch:
    - lw/sw (0x23/0x2B) -> MEMADR.
    - R-type, funct in {add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra} -> EXEC.
    - R-type jr, j (0x02), jal (0x03) -> JUMP.
    - beq/bne (0x04/0x05) -> BRANCH.
    - addi, addiu, andi, ori, xori, slti, lui -> IEXEC.
    - anything else -> ILL.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=000. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until `mem_ready`, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01. Retires. -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until `mem_ready`, then retires -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. -> RWB.
- RWB: RegWrite=1, RegDst=01, MemtoReg=00. Retires. -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01.
  - pc_en = `zero` XNOR is_beq, i.e. taken when zero=1 for beq, zero=0 for bne.
  - Retires. -> FETCH.
- JUMP:
  - j: pc_en=1, PCSource=10.
  - jal: pc_en=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
  - jr: pc_en=1, PCSource=11.
  - Retires. -> FETCH.
- IEXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - ExtOp=0 for andi/ori/xori/lui, 1 otherwise.
  - ALUOp: addi/addiu=000, andi=011, ori=100, xori=101, lui=110, slti=111.
  - -> IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00. Retires. -> FETCH.
- ILL: `illegal`=1 for exactly this cycle. No write enables asserted. Not counted as retired. -> FETCH.
- Retire: `instr_done`=1 in the retiring cycle, and `instr_count` increments at that clock edge. The counter wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset:
  - `rst`=1 forces state=FETCH, `instr_count`=0 and latched opcode/funct=0 immediately, with no clock edge needed.
  - While `rst`=1, every output is gated to 0 and `state` reads 0.
  - The first fetch begins on the first edge after release.
- Reset mid-operation (e.g. in MEMWR): the in-flight instruction is abandoned, no write enables remain asserted, and the count is not incremented.
- Latency with zero wait states (`mem_ready` held at 1):
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne, j/jal/jr: 3 cycles.
  - Illegal encoding: 3 cycles.
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. MemRead/MemWrite and IorD stay stable throughout the wait.
- With WAIT_MEM=0, `mem_ready` is treated as constantly 1.
- Changes on `opcode`/`funct` outside DECODE have no effect on the current instruction.

## Test plan
- Reset, then lw (opcode 0x23) with `mem_ready`=1: state sequence 0,1,2,3,4,0. `instr_done` pulses once, `instr_count`=1. MEMWB drives RegWrite=1, MemtoReg=01.
- sw with `mem_ready` low for 3 cycles in MEMWR: MemWrite=1, IorD=1 held for 4 cycles, no retire until `mem_ready`=1. Total 7 cycles.
- beq with zero=1 gives pc_en=1 in BRANCH. bne with zero=1 gives pc_en=0. Both increment `instr_count`.
- jal: JUMP asserts pc_en=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. jr (funct 0x08) gives PCSource=11, RegWrite=0.
- opcode 0x3F: ILL asserts `illegal` for one cycle with all write enables 0, returns to FETCH, `instr_count` unchanged. andi gives ExtOp=0, ALUOp=011.
- CNT_W=4, 16 back-to-back addi: `instr_count` wraps 15 -> 0. `rst` pulsed mid-MEMRD: state=0 and all outputs 0 with no clock edge.

Source files
------------

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control unit: Moore sequencer, retire counter, illegal-encoding flag
// Outputs decode from the registered state plus the opcode/funct latched in DECODE.

module mc_ctrl #(
    parameter int unsigned WAIT_MEM = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_ILL    = 4'd12
    } state_t;

    state_t           r_state;
    logic [5:0]       r_op;
    logic [5:0]       r_fn;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_dispatch;
    logic             w_rdy;

    assign w_rdy       = (WAIT_MEM != 0) ? mem_ready : 1'b1;
    assign instr_count = r_cnt;
    assign state       = r_state;

    // Dispatch looks at the live IR fields; only DECODE consumes it.
    always_comb begin
        w_dispatch = S_ILL;
        if (opcode == OP_LW || opcode == OP_SW) begin
            w_dispatch = S_MEMADR;
        end else if (opcode == OP_R) begin
            if (funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03})
                w_dispatch = S_EXEC;
            else if (funct == FN_JR)
                w_dispatch = S_JUMP;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
            w_dispatch = S_JUMP;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            w_dispatch = S_BRANCH;
        end else if (opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                                    OP_ORI, OP_XORI, OP_LUI}) begin
            w_dispatch = S_IEXEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= 6'h00;
            r_fn    <= 6'h00;
            r_cnt   <= '0;
        end else begin
            if (instr_done)
                r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_FETCH:  if (w_rdy) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op    <= opcode;
                    r_fn    <= funct;
                    r_state <= w_dispatch;
                end
                S_MEMADR: r_state <= (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (w_rdy) r_state <= S_MEMWB;
                S_MEMWR:  if (w_rdy) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_IEXEC:  r_state <= S_IWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Reset gates every control output so nothing strobes while rst is high.
    always_comb begin
        pc_en      = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ExtOp      = 1'b0;
        ALUOp      = 3'b000;
        PCSource   = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = w_rdy;
                    pc_en   = w_rdy;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b01;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = w_rdy;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b010;
                end
                S_RWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b01;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = 3'b001;
                    PCSource   = 2'b01;
                    pc_en      = zero ~^ (r_op == OP_BEQ);
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_en      = 1'b1;
                    PCSource   = (r_op == OP_R && r_fn == FN_JR) ? 2'b11 : 2'b10;
                    instr_done = 1'b1;
                    if (r_op == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ExtOp   = !(r_op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI});
                    case (r_op)
                        OP_ANDI: ALUOp = 3'b011;
                        OP_ORI:  ALUOp = 3'b100;
                        OP_XORI: ALUOp = 3'b101;
                        OP_LUI:  ALUOp = 3'b110;
                        OP_SLTI: ALUOp = 3'b111;
                        default: ALUOp = 3'b000;
                    endcase
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_ILL:   illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against an instruction-level model
// Two instances share stimulus; the CNT_W=4 copy exercises counter wrap.

module tb_mc_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       asa;
        logic [1:0] asb;
        logic       ext;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       ill;
        logic       done;
    } ctl_t;

    localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3, C_JMP = 4, C_BR = 5, C_I = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        pc_en, IorD, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA, ExtOp, illegal, instr_done;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [31:0] instr_count;
    logic [3:0]  state;

    logic        d4_pc_en, d4_IorD, d4_IRWrite, d4_MemRead, d4_MemWrite, d4_RegWrite, d4_ALUSrcA;
    logic        d4_ExtOp, d4_illegal, d4_instr_done;
    logic [1:0]  d4_RegDst, d4_MemtoReg, d4_ALUSrcB, d4_PCSource;
    logic [2:0]  d4_ALUOp;
    logic [3:0]  d4_instr_count;
    logic [3:0]  d4_state;

    ctl_t obs, obs4;
    assign obs  = {pc_en, IorD, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
                   ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, illegal, instr_done};
    assign obs4 = {d4_pc_en, d4_IorD, d4_IRWrite, d4_MemRead, d4_MemWrite, d4_RegWrite, d4_RegDst,
                   d4_MemtoReg, d4_ALUSrcA, d4_ALUSrcB, d4_ExtOp, d4_ALUOp, d4_PCSource,
                   d4_illegal, d4_instr_done};

    mc_ctrl u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUOp(ALUOp), .PCSource(PCSource), .illegal(illegal),
        .instr_done(instr_done), .instr_count(instr_count), .state(state)
    );

    mc_ctrl #(.WAIT_MEM(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(d4_pc_en), .IorD(d4_IorD), .IRWrite(d4_IRWrite), .MemRead(d4_MemRead),
        .MemWrite(d4_MemWrite), .RegWrite(d4_RegWrite), .RegDst(d4_RegDst), .MemtoReg(d4_MemtoReg),
        .ALUSrcA(d4_ALUSrcA), .ALUSrcB(d4_ALUSrcB), .ExtOp(d4_ExtOp), .ALUOp(d4_ALUOp),
        .PCSource(d4_PCSource), .illegal(d4_illegal), .instr_done(d4_instr_done),
        .instr_count(d4_instr_count), .state(d4_state)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned m_cnt  = 0;
    logic [5:0]  m_op, m_fn;
    logic [11:0] pool [0:30] = '{
        {6'h23, 6'h00}, {6'h2B, 6'h00},
        {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24},
        {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2B},
        {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03},
        {6'h00, 6'h08}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00},
        {6'h08, 6'h00}, {6'h09, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h0E, 6'h00},
        {6'h0A, 6'h00}, {6'h0F, 6'h00},
        {6'h3F, 6'h00}, {6'h0B, 6'h00}, {6'h00, 6'h09}, {6'h00, 6'h18}
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03}) return C_R;
            if (fn == 6'h08) return C_JMP;
            return C_ILL;
        end
        if (op == 6'h02 || op == 6'h03) return C_JMP;
        if (op == 6'h04 || op == 6'h05) return C_BR;
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) return C_I;
        return C_ILL;
    endfunction

    // Expected datapath controls for one cycle of the given step of an instruction.
    function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic rdy, input logic z);
        ctl_t e = '0;
        case (st)
            0:  begin e.mrd = 1; e.asb = 2'b01; e.pc_en = rdy; e.irw = rdy; end
            1:  e.asb = 2'b11;
            2:  begin e.asa = 1; e.asb = 2'b10; e.ext = 1; end
            3:  begin e.mrd = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 2'b01; e.done = 1; end
            5:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
            6:  begin e.asa = 1; e.aop = 3'b010; end
            7:  begin e.rw = 1; e.rdst = 2'b01; e.done = 1; end
            8:  begin e.asa = 1; e.aop = 3'b001; e.pcs = 2'b01; e.done = 1;
                      e.pc_en = (op == 6'h04) ? z : !z; end
            9:  begin e.pc_en = 1; e.done = 1; e.pcs = (op == 6'h00) ? 2'b11 : 2'b10;
                      if (op == 6'h03) begin e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10; end end
            10: begin
                e.asa = 1; e.asb = 2'b10;
                e.ext = !(op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F});
                case (op)
                    6'h0C: e.aop = 3'b011;
                    6'h0D: e.aop = 3'b100;
                    6'h0E: e.aop = 3'b101;
                    6'h0F: e.aop = 3'b110;
                    6'h0A: e.aop = 3'b111;
                    default: e.aop = 3'b000;
                endcase
            end
            11: begin e.rw = 1; e.done = 1; end
            12: e.ill = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    // Called just after a rising edge: drive one cycle, check at the falling edge.
    task automatic step(input int est, input logic rdy, input logic z);
        ctl_t e;
        mem_ready = rdy;
        zero      = z;
        if (est == 1) begin
            opcode = m_op;
            funct  = m_fn;
        end else begin
            opcode = 6'($urandom_range(63));
            funct  = 6'($urandom_range(63));
        end
        e = exp_ctl(est, m_op, rdy, z);
        @(negedge clk);
        check("state", 64'(state), 64'(est));
        check("ctl", 64'(obs), 64'(e));
        check("count", 64'(instr_count), 64'(m_cnt));
        check("state4", 64'(d4_state), 64'(est));
        check("ctl4", 64'(obs4), 64'(e));
        check("count4", 64'(d4_instr_count), 64'(m_cnt % 16));
        if (e.done) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int wf, input int wm, output int cyc);
        m_op = op;
        m_fn = fn;
        cyc  = 0;
        for (int k = 0; k <= wf; k++) begin step(0, k == wf, rb()); cyc++; end
        step(1, rb(), rb()); cyc++;
        case (cls(op, fn))
            C_LW: begin
                step(2, rb(), rb()); cyc++;
                for (int k = 0; k <= wm; k++) begin step(3, k == wm, rb()); cyc++; end
                step(4, rb(), rb()); cyc++;
            end
            C_SW: begin
                step(2, rb(), rb()); cyc++;
                for (int k = 0; k <= wm; k++) begin step(5, k == wm, rb()); cyc++; end
            end
            C_R:   begin step(6, rb(), rb()); step(7, rb(), rb()); cyc += 2; end
            C_I:   begin step(10, rb(), rb()); step(11, rb(), rb()); cyc += 2; end
            C_BR:  begin step(8, rb(), z); cyc++; end
            C_JMP: begin step(9, rb(), rb()); cyc++; end
            default: begin step(12, rb(), rb()); cyc++; end
        endcase
    endtask

    int cyc;
    int wf, wm;
    logic [11:0] pick;
    logic [5:0]  r_fn_pick;

    initial begin
        #2;
        check("rst_state", 64'(state), 64'd0);
        check("rst_ctl", 64'(obs), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_instr(6'h23, 6'h00, 1'b0, 0, 0, cyc); check("lat_lw", 64'(cyc), 64'd5);
        do_instr(6'h2B, 6'h00, 1'b0, 0, 3, cyc); check("lat_sw_wait", 64'(cyc), 64'd7);
        do_instr(6'h2B, 6'h00, 1'b0, 0, 0, cyc); check("lat_sw", 64'(cyc), 64'd4);
        do_instr(6'h04, 6'h00, 1'b1, 0, 0, cyc); check("lat_beq", 64'(cyc), 64'd3);
        do_instr(6'h05, 6'h00, 1'b1, 0, 0, cyc);
        do_instr(6'h03, 6'h00, 1'b0, 0, 0, cyc); check("lat_jal", 64'(cyc), 64'd3);
        do_instr(6'h00, 6'h08, 1'b0, 0, 0, cyc);
        do_instr(6'h3F, 6'h00, 1'b0, 0, 0, cyc); check("lat_ill", 64'(cyc), 64'd3);
        do_instr(6'h0C, 6'h00, 1'b0, 0, 0, cyc); check("lat_andi", 64'(cyc), 64'd4);
        do_instr(6'h00, 6'h20, 1'b0, 2, 0, cyc); check("lat_add_fwait", 64'(cyc), 64'd6);
        for (int i = 0; i < 16; i++) do_instr(6'h08, 6'h00, 1'b0, 0, 0, cyc);

        // Abandon an lw mid-MEMRD with an asynchronous reset.
        m_op = 6'h23;
        m_fn = 6'h00;
        step(0, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        step(2, 1'b0, 1'b0);
        step(3, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_state", 64'(state), 64'd0);
        check("midrst_ctl", 64'(obs), 64'd0);
        check("midrst_count", 64'(instr_count), 64'd0);
        check("midrst_ctl4", 64'(obs4), 64'd0);
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            pick      = pool[$urandom_range(30)];
            r_fn_pick = (pick[11:6] == 6'h00) ? pick[5:0] : 6'($urandom_range(63));
            wf = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
            wm = ($urandom_range(2) == 0) ? int'($urandom_range(3)) : 0;
            do_instr(pick[11:6], r_fn_pick, rb(), wf, wm, cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
